// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and helpers for the load/store unit.
//               lsu_op_t     - request operation encoding
//               lsu_state_t  - controller states
//               is_load      - op is one of LW/LH/LHU/LB/LBU
//               is_misaligned- op/offset pair violates natural alignment
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } lsu_state_t;

    function automatic logic is_load(lsu_op_t op);
        return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
    endfunction

    function automatic logic is_misaligned(lsu_op_t op, logic [1:0] offs);
        case (op)
            LW, SW:       return offs != 2'b00;
            LH, LHU, SH:  return offs[0];
            default:      return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Request/response channel between the MEM stage (master) and
//               the load/store unit (slave).
//               req_valid/req_ready - handshake, accept when both high
//               req_op/addr/wdata   - operation, byte address, store data
//               done                - one-cycle completion pulse
//               rdata               - load result (holds between loads)
//               err                 - misaligned request, valid with done
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              done;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, done, rdata, err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, done, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane
// Description : Little-endian byte-lane logic shared by loads and stores.
//               i_word   - source word (memory data or merge buffer)
//               i_wdata  - store data (low byte/halfword used for SB/SH)
//               i_op     - operation
//               i_offs   - byte offset addr[1:0]
//               o_load   - extracted lane, sign/zero extended per op
//               o_merge  - i_word with the op's lane replaced (SW: i_wdata)
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane
    import lsu_pkg::*;
(
    input  lsu_op_t     i_op,
    input  logic [1:0]  i_offs,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_offs)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_offs[1] ? i_word[31:16] : i_word[15:0];

        case (i_op)
            LH:      o_load = {{16{w_half[15]}}, w_half};
            LHU:     o_load = {16'h0000, w_half};
            LB:      o_load = {{24{w_byte[7]}}, w_byte};
            LBU:     o_load = {24'h000000, w_byte};
            default: o_load = i_word;
        endcase

        o_merge = i_word;
        case (i_op)
            SB: begin
                case (i_offs)
                    2'd0:    o_merge[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge[23:16] = i_wdata[7:0];
                    default: o_merge[31:24] = i_wdata[7:0];
                endcase
            end
            SH: begin
                if (i_offs[1]) o_merge[31:16] = i_wdata[15:0];
                else           o_merge[15:0]  = i_wdata[15:0];
            end
            default: o_merge = i_wdata;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multicycle initiator between the MEM stage and data_memory.
//               Word accesses go straight through; sub-word stores are done
//               as read-modify-write; sub-word loads are extracted/extended.
//               clk, rst_n       - clock, synchronous active-low reset
//               bus (slave)      - request handshake and response
//               mem_write        - write strobe to data_memory
//               mem_address      - word index (addr >> 2) mod MEM_WORDS
//               mem_write_data   - word to write
//               mem_read_data    - combinational read of mem[mem_address]
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.slave    bus,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [31:0]         mem_write_data,
    input  logic [31:0]         mem_read_data
);
    localparam logic [ADDR_W-1:0] c_words = ADDR_W'(MEM_WORDS);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    lsu_op_t           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [31:0]       r_rdata;
    logic              r_err;

    lsu_op_t           w_req_op;
    logic              w_accept;
    logic              w_req_mis;
    logic              w_subword_st;
    logic              w_wr;
    logic [ADDR_W-1:0] w_word_addr;
    logic [31:0]       w_lane_word;
    logic [31:0]       w_load;
    logic [31:0]       w_merge;

    assign w_req_op     = lsu_op_t'(bus.req_op);
    assign w_accept     = bus.req_valid && (r_state == ST_IDLE);
    assign w_req_mis    = is_misaligned(w_req_op, bus.req_addr[1:0]);
    assign w_subword_st = (r_op == SH) || (r_op == SB);
    assign w_word_addr  = {2'b00, r_addr[ADDR_W-1:2]};

    // During WRITE the lane unit merges into the buffered word; otherwise it
    // works on the live memory read (load extract, SW pass-through).
    assign w_lane_word  = (r_state == ST_WRITE) ? r_buf : mem_read_data;

    lsu_lane u_lane (
        .i_op    (r_op),
        .i_offs  (r_addr[1:0]),
        .i_word  (w_lane_word),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_merge (w_merge)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = w_req_mis ? ST_DONE : ST_ACCESS;
            ST_ACCESS: w_next = w_subword_st ? ST_WRITE : ST_DONE;
            ST_WRITE:  w_next = ST_DONE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.req_ready = (r_state == ST_IDLE);
        bus.done      = (r_state == ST_DONE);
        w_wr          = ((r_state == ST_ACCESS) && (r_op == SW)) || (r_state == ST_WRITE);
        // Gate with reset so a write strobe never escapes in a reset cycle.
        mem_write     = rst_n && w_wr;
    end

    assign mem_address    = w_word_addr % c_words;
    assign mem_write_data = w_merge;
    assign bus.rdata      = r_rdata;
    assign bus.err        = r_err;

    // Request latch, merge buffer and load result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= LW;
            r_addr  <= '0;
            r_wdata <= '0;
            r_buf   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= w_req_op;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_err   <= w_req_mis;
            end
            if (r_state == ST_ACCESS) begin
                if (is_load(r_op)) r_rdata <= w_load;
                if (w_subword_st)  r_buf   <= mem_read_data;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a word memory,
//               a transaction-level reference model and a per-cycle checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    localparam int NW = 1024;
    localparam logic [2:0] T_LW = 3'd0, T_LH = 3'd1, T_LHU = 3'd2, T_LB = 3'd3,
                           T_LBU = 3'd4, T_SW = 3'd5, T_SH = 3'd6, T_SB = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [31:0] tb_mem  [NW];
    logic [31:0] ref_mem [NW];
    logic [31:0] cur_rdata = 32'h0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        int          acc;
        int          lat;
        int          wcyc;
        logic        mis;
        logic        is_ld;
        logic        is_st;
        int          idx;
        logic [31:0] exp_rdata;
        logic [31:0] new_word;
    } txn_t;
    txn_t q[$];

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .MEM_WORDS(NW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // data_memory stand-in
    assign mem_read_data = tb_mem[mem_address[9:0]];
    always @(posedge clk) if (mem_write) tb_mem[mem_address[9:0]] <= mem_write_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int op_size(logic [2:0] op);
        if (op == T_LW || op == T_SW) return 4;
        if (op == T_LH || op == T_LHU || op == T_SH) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] op, logic [31:0] w, int b);
        logic [31:0] s;
        s = w >> (8 * b);
        case (op)
            T_LB:    return {{24{s[7]}}, s[7:0]};
            T_LBU:   return {24'h0, s[7:0]};
            T_LH:    return {{16{s[15]}}, s[15:0]};
            T_LHU:   return {16'h0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_store(logic [2:0] op, logic [31:0] old, logic [31:0] wd, int b);
        logic [31:0] mask;
        if (op == T_SW) return wd;
        mask = ((op == T_SH) ? 32'h0000_FFFF : 32'h0000_00FF) << (8 * b);
        return (old & ~mask) | ((wd << (8 * b)) & mask);
    endfunction

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        txn_t t;
        int   off;
        if (!rst_n) begin
            chk("mem_write_in_reset", {31'h0, mem_write}, 32'h0);
        end else if (q.size() == 0) begin
            chk("idle_ready", {31'h0, bus.req_ready}, 32'h1);
            chk("idle_done", {31'h0, bus.done}, 32'h0);
            chk("idle_mem_write", {31'h0, mem_write}, 32'h0);
            chk("idle_rdata", bus.rdata, cur_rdata);
        end else begin
            t   = q[0];
            off = cyc - t.acc;
            chk("busy_ready", {31'h0, bus.req_ready}, 32'h0);
            chk("done", {31'h0, bus.done}, {31'h0, off == t.lat});
            chk("mem_write", {31'h0, mem_write}, {31'h0, off == t.wcyc});
            if (off == t.wcyc) begin
                chk("mem_address", mem_address, t.idx);
                chk("mem_write_data", mem_write_data, t.new_word);
            end
            if (off >= t.lat) begin
                chk("err", {31'h0, bus.err}, {31'h0, t.mis});
                if (t.is_ld && !t.mis) cur_rdata = t.exp_rdata;
                if (t.is_st && !t.mis) ref_mem[t.idx] = t.new_word;
                void'(q.pop_front());
            end
            chk("rdata", bus.rdata, cur_rdata);
        end
    end

    // ---------------- driver ----------------
    // Called at #1 after a rising edge; returns at the same phase in the first
    // cycle the unit is idle again.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input bit rst_mid);
        txn_t t;
        int   w = 0;
        int   b;
        while (!bus.req_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!bus.req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: req_ready stuck at 0 for %0d cycles", w);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        b           = int'(addr % 4);
        t.acc       = cyc;
        t.idx       = int'((addr / 4) % NW);
        t.mis       = (b % op_size(op)) != 0;
        t.is_ld     = op <= T_LBU;
        t.is_st     = !t.is_ld;
        t.lat       = t.mis ? 1 : ((op == T_SH || op == T_SB) ? 3 : 2);
        t.wcyc      = t.mis ? -1 : (op == T_SW ? 1 : ((op == T_SH || op == T_SB) ? 2 : -1));
        t.exp_rdata = m_load(op, ref_mem[t.idx], b);
        t.new_word  = m_store(op, ref_mem[t.idx], wd, b);
        @(posedge clk); #1;
        q.push_back(t);
        if (rst_mid) begin
            bus.req_valid = 1'b0;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            q.delete();
            cur_rdata = 32'h0;
            return;
        end
        // Noise on the request port while busy must be ignored.
        for (int k = 1; k <= t.lat; k++) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_op    = 3'($urandom);
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < NW; i++) begin
            tb_mem[i]  = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_err", {31'h0, bus.err}, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_mem_address", mem_address, 32'h0);
        @(posedge clk); #1;

        // Directed sequence with literal expectations
        do_req(T_SW, 32'd8, 32'h8899_AABB, 1'b0);
        chk("SW8_word", tb_mem[2], 32'h8899_AABB);
        do_req(T_LW, 32'd8, 32'h0, 1'b0);
        chk("LW8", bus.rdata, 32'h8899_AABB);
        do_req(T_LB, 32'd9, 32'h0, 1'b0);
        chk("LB9", bus.rdata, 32'hFFFF_FFAA);
        chk("LB9_model", cur_rdata, 32'hFFFF_FFAA);
        do_req(T_LBU, 32'd9, 32'h0, 1'b0);
        chk("LBU9", bus.rdata, 32'h0000_00AA);
        do_req(T_LHU, 32'd10, 32'h0, 1'b0);
        chk("LHU10", bus.rdata, 32'h0000_8899);
        do_req(T_LH, 32'd10, 32'h0, 1'b0);
        chk("LH10", bus.rdata, 32'hFFFF_8899);
        do_req(T_SH, 32'd10, 32'h0000_1234, 1'b0);
        do_req(T_LW, 32'd8, 32'h0, 1'b0);
        chk("SH10_LW8", bus.rdata, 32'h1234_AABB);
        do_req(T_SB, 32'd4095, 32'h0000_007F, 1'b0);
        chk("SB4095_word", tb_mem[1023], 32'h7F00_0000);
        chk("SB4095_model", ref_mem[1023], 32'h7F00_0000);
        do_req(T_LW, 32'd6, 32'h0, 1'b0);
        chk("LW6_rdata_kept", bus.rdata, 32'h1234_AABB);

        // Reset while an SB sits in ACCESS
        do_req(T_SB, 32'd8, 32'h0000_0055, 1'b1);
        @(negedge clk);
        chk("rstmid_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rstmid_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rstmid_mem_address", mem_address, 32'h0);
        chk("rstmid_word", tb_mem[2], 32'h1234_AABB);
        @(posedge clk); #1;
        do_req(T_LW, 32'd8, 32'h0, 1'b0);
        chk("rstmid_LW8", bus.rdata, 32'h1234_AABB);

        // Randomized traffic over a small window with wrapping upper bits
        for (int n = 0; n < 400; n++) begin
            op   = 3'($urandom_range(0, 7));
            addr = ($urandom & 32'h0000_003F) | (($urandom_range(0, 3) == 0) ? ($urandom << 12) : 32'h0);
            if ($urandom_range(0, 7) == 0) addr = addr | 32'h0000_0FC0;
            do_req(op, addr, $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NW; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multicycle initiator that sits between the datapath's MEM stage and `data_memory`. It turns MIPS load/store requests (LW, LH, LHU, LB, LBU, SW, SH, SB) into word-wide accesses on the memory's `mem_write`/`address`/`write_data`/`read_data` port. Sub-word stores are done as read-modify-write, and sub-word loads are extracted and extended. Each request is handled with a valid/ready handshake and a one-cycle completion pulse.

## Interface
Parameters:
- `ADDR_W`, 32: width of the byte address and of `mem_address`.
- `MEM_WORDS`, 1024: depth of `data_memory` in words. The word index wraps modulo this value.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit is idle and accepts the request this cycle.
- `req_op`  in  3: operation code (`lsu_op_t`).
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data; low byte or halfword is used for SB/SH.
- `done`  out  1: one-cycle completion pulse.
- `rdata`  out  32: load result.
- `err`  out  1: misaligned request; valid while `done`=1.
- `mem_write`  out  1: write strobe to `data_memory`.
- `mem_address`  out  ADDR_W: word index, equal to `req_addr[ADDR_W-1:2]` mod `MEM_WORDS`, zero-extended.
- `mem_write_data`  out  32: word to write.
- `mem_read_data`  in  32: combinational read of `mem[mem_address]`.

## Operation
- Byte lanes are little-endian: `addr[1:0]`=0 selects bits 7:0 and 3 selects bits 31:24. A halfword at `addr[1]`=0 occupies bits 15:0.
- Alignment rules:
  - LW and SW require `addr[1:0]`=0.
  - LH, LHU and SH require `addr[0]`=0.
  - Bytes are always aligned.
- A request is accepted on a rising edge where `req_valid`=1 and `req_ready`=1. On acceptance the unit latches op, address and write data. Inputs are ignored while the unit is busy.
- State machine states are IDLE, ACCESS, WRITE and DONE.
  - IDLE: `req_ready`=1. On accept, a misaligned request goes to DONE with `err`=1. Otherwise it goes to ACCESS.
  - ACCESS: `mem_address` is driven from the latched address.
    - Loads: extract the lane, sign-extend (LB, LH) or zero-extend (LBU, LHU), register the result into `rdata`, then go to DONE.
    - SW: `mem_write`=1 with `mem_write_data` equal to the latched wdata, then go to DONE.
    - SB/SH: register `mem_read_data` into the merge buffer, then go to WRITE.
  - WRITE: `mem_write`=1, `mem_address` unchanged. `mem_write_data` is the buffer with the selected lane replaced by wdata. Then go to DONE.
  - DONE: `done`=1 for exactly one cycle, then return to IDLE.
- `rdata` updates only on a successful load and otherwise holds its value. Stores and errored requests leave it unchanged.
- `err` is cleared when the next request is accepted.
- A misaligned request never asserts `mem_write`.
- `mem_write` is decoded combinationally from the state and asserts only in ACCESS(SW) and WRITE.

## Timing
- Reset: when `rst_n`=0 at a rising edge, the state goes to IDLE and `rdata`=0, `err`=0, `done`=0. The merge buffer and latched request are cleared. In the cycle after reset, `req_ready`=1, `mem_write`=0 and `mem_address`=0.
- Latency counted from the accepting edge E:
  - `done` is high in cycle E+2 for loads and SW.
  - `done` is high in cycle E+3 for SB/SH.
  - `done` is high in cycle E+1 for misaligned requests.
- Memory write for SW takes effect at the edge ending ACCESS. For SB/SH it takes effect at the edge ending WRITE.
- Back-to-back requests: `req_ready` rises in the cycle after DONE, so the minimum interval between acceptances is 3 cycles (loads, SW), 4 cycles (SB/SH) or 2 cycles (misaligned).
- Reset mid-operation: a pending RMW is abandoned, no write is issued in later cycles, and memory keeps its prior contents.
- Address wrap: word index `MEM_WORDS`-1 is legal. Higher indices wrap modulo `MEM_WORDS`.

## Structure
- The shared package `lsu_pkg` holds:
  - `lsu_op_t`: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
  - `lsu_state_t`.
  - Helpers `is_load(op)` and `is_misaligned(op, addr[1:0])`.
- Combinational sub-module `lsu_lane` implements lane extract with sign/zero extend and lane merge. It is instantiated once and shared by the load and store paths.

## Test plan
- SW to addr 8 with wdata 32'h8899_AABB, then LW addr 8:
  - SW gives `mem_write`=1 for exactly one cycle with `mem_address`=2 and `done` at E+2.
  - LW returns `rdata`=32'h8899_AABB.
- Lane extract from the word 32'h8899_AABB:
  - LB addr 9 gives 32'hFFFF_FFAA.
  - LBU addr 9 gives 32'h0000_00AA.
  - LHU addr 10 gives 32'h0000_8899.
  - LH addr 10 gives 32'hFFFF_8899.
- SH addr 10 with wdata 32'h0000_1234:
  - One read cycle, then one write cycle, `done` at E+3.
  - Word 2 becomes 32'h1234_AABB, confirmed by a following LW.
- SB addr 4095 with wdata 32'h0000_007F on a zeroed word 1023: word 1023 becomes 32'h7F00_0000 and `mem_address`=1023.
- LW addr 6 (misaligned):
  - `err`=1 and `done` at E+1.
  - No `mem_write`, and `rdata` keeps its prior value.
- SB accepted, then `rst_n`=0 during ACCESS:
  - No `mem_write` is ever asserted for that request and the target word is unchanged.
  - `req_ready`=1 in the cycle after reset.
